// File: rtl/vram_write_buffer_if.sv
// Bus bundle for the VRAM write buffer: rasteriser write port, swap request,
// VRAM sel/ack write port and status. master = environment side, slave = buffer.
interface vram_write_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 4,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_sel_i;
  logic              in_wr_i;
  logic [MASK_W-1:0] in_mask_i;
  logic [ADDR_W-1:0] in_addr_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              swap_req_i;
  logic              swap_o;
  logic              vram_sel_o;
  logic              vram_wr_o;
  logic [MASK_W-1:0] vram_mask_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic [DATA_W-1:0] vram_data_out_o;
  logic              vram_ack_i;
  logic [LVL_W-1:0]  level_o;
  logic              overflow_o;

  modport master (
    output in_sel_i, in_wr_i, in_mask_i, in_addr_i, in_data_i, swap_req_i, vram_ack_i,
    input  in_ready_o, swap_o, vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o,
           vram_data_out_o, level_o, overflow_o
  );

  modport slave (
    input  in_sel_i, in_wr_i, in_mask_i, in_addr_i, in_data_i, swap_req_i, vram_ack_i,
    output in_ready_o, swap_o, vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o,
           vram_data_out_o, level_o, overflow_o
  );
endinterface

// File: rtl/vram_write_buffer.sv
// VRAM write buffer: DEPTH-entry FIFO of masked writes with a registered
// sel/ack output stage, sticky overflow flag, and a swap sequencer that
// releases the display swap only once every earlier write has been acked.
// level counts every entry not yet acked, including the one on the VRAM bus;
// the FIFO slot of the presented entry is freed only on its ack.
module vram_write_buffer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 4,
  parameter int DEPTH  = 8
) (
  input logic          clk,
  input logic          reset_i,
  vram_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = MASK_W + ADDR_W + DATA_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } swap_state_t;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_run;
  logic              r_ovf;
  logic              r_vsel;
  logic [MASK_W-1:0] r_vmask;
  logic [ADDR_W-1:0] r_vaddr;
  logic [DATA_W-1:0] r_vdata;
  swap_state_t       r_state;
  swap_state_t       w_next_state;

  logic              w_full;
  logic              w_in_ready;
  logic              w_wr_req;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_load;
  logic [LVL_W-1:0]  w_avail;
  logic [PTR_W-1:0]  w_head;
  logic [ENT_W-1:0]  w_head_ent;

  // Handshake decode; the output stage reloads only from entries stored before this edge.
  always_comb begin
    w_full     = (r_level == FULL_LVL);
    w_in_ready = r_run && !w_full && (r_state == ST_IDLE);
    w_wr_req   = bus.in_sel_i && bus.in_wr_i;
    w_push     = w_wr_req && w_in_ready;
    w_drop     = w_wr_req && !w_in_ready;
    w_pop      = r_vsel && bus.vram_ack_i;
    w_load     = !r_vsel || bus.vram_ack_i;
    w_avail    = r_level - LVL_W'(w_pop);
    w_head     = r_rptr + PTR_W'(w_pop);
    w_head_ent = r_mem[w_head];
  end

  // FIFO storage: accepted writes land at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.in_mask_i, bus.in_addr_i, bus.in_data_i};
    end
  end

  // Pointers, occupancy, ready enable and sticky overflow.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_level <= {LVL_W{1'b0}};
      r_run   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_rptr  <= w_head;
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1'b1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Registered VRAM request: hold until acked, then present the next stored entry or drop sel.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_vsel  <= 1'b0;
      r_vmask <= {MASK_W{1'b0}};
      r_vaddr <= {ADDR_W{1'b0}};
      r_vdata <= {DATA_W{1'b0}};
    end else if (w_load) begin
      if (w_avail != {LVL_W{1'b0}}) begin
        r_vsel  <= 1'b1;
        r_vmask <= w_head_ent[ENT_W-1 -: MASK_W];
        r_vaddr <= w_head_ent[DATA_W +: ADDR_W];
        r_vdata <= w_head_ent[DATA_W-1:0];
      end else begin
        r_vsel  <= 1'b0;
      end
    end
  end

  // Swap sequencer state register.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Swap sequencer next state: wait for a fully drained buffer, then pulse once.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.swap_req_i) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if ((r_level == {LVL_W{1'b0}}) && !r_vsel) begin
          w_next_state = ST_FIRE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_FIRE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign bus.in_ready_o      = w_in_ready;
  assign bus.swap_o          = (r_state == ST_FIRE);
  assign bus.vram_sel_o      = r_vsel;
  assign bus.vram_wr_o       = r_vsel;
  assign bus.vram_mask_o     = r_vmask;
  assign bus.vram_addr_o     = r_vaddr;
  assign bus.vram_data_out_o = r_vdata;
  assign bus.level_o         = r_level;
  assign bus.overflow_o      = r_ovf;
endmodule

// File: tb/tb_vram_write_buffer.sv
// Self-checking bench for vram_write_buffer: directed scenarios plus a
// randomized stream checked against a queue-based reference model.
module tb_vram_write_buffer;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MASK_W = 4;
  localparam int DEPTH  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                edge_n;
  } ent_t;

  logic clk;
  logic reset_i;
  int   errors = 0;
  int   checks = 0;

  // reference model: queue of un-acked writes tagged with the edge they were accepted on
  ent_t q[$];
  int   edge_cnt = 0;
  bit   m_run, m_wait, m_fire, m_ovf, m_sel;

  vram_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)) bus ();

  vram_write_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_i(reset_i), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit exp_ready();
    return m_run && (q.size() < DEPTH) && !m_wait && !m_fire;
  endfunction

  task automatic clear_inputs();
    bus.in_sel_i = 1'b0; bus.in_wr_i = 1'b0; bus.in_mask_i = '0;
    bus.in_addr_i = '0; bus.in_data_i = '0; bus.swap_req_i = 1'b0;
  endtask

  task automatic set_write(input logic [MASK_W-1:0] m, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.in_sel_i = 1'b1; bus.in_wr_i = 1'b1;
    bus.in_mask_i = m; bus.in_addr_i = a; bus.in_data_i = d;
  endtask

  task automatic model_clear();
    q.delete();
    m_run = 1'b0; m_wait = 1'b0; m_fire = 1'b0; m_ovf = 1'b0; m_sel = 1'b0;
  endtask

  // advance one clock edge and apply the buffer rules to the model
  task automatic tick();
    bit   rdy, push, hs;
    ent_t e;
    rdy  = exp_ready();
    push = bus.in_sel_i && bus.in_wr_i && rdy;
    if (bus.in_sel_i && bus.in_wr_i && !rdy) m_ovf = 1'b1;
    hs   = m_sel && bus.vram_ack_i;
    if (m_fire) m_fire = 1'b0;
    else if (m_wait) begin
      if (q.size() == 0) begin m_wait = 1'b0; m_fire = 1'b1; end
    end else if (bus.swap_req_i) m_wait = 1'b1;
    e.mask = bus.in_mask_i; e.addr = bus.in_addr_i; e.data = bus.in_data_i;
    @(posedge clk);
    edge_cnt++;
    e.edge_n = edge_cnt;
    if (hs) void'(q.pop_front());
    if (push) q.push_back(e);
    m_run = 1'b1;
    m_sel = (q.size() > 0) && (q[0].edge_n < edge_cnt);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    clear_inputs();
    bus.vram_ack_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    clear_inputs();
    bus.vram_ack_i = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.in_ready_o, bus.vram_sel_o, bus.vram_wr_o, bus.swap_o, bus.overflow_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {bus.in_ready_o, bus.vram_sel_o, bus.vram_wr_o, bus.swap_o, bus.overflow_o}); end
    checks++; if (bus.level_o !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level_o); end
    reset_i = 1'b1;
    #1;
    checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_pre_edge: got %b want 0", bus.in_ready_o); end
    tick();
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_post_edge: got %b want 1", bus.in_ready_o); end
  endtask

  task automatic test_single_write();
    do_reset(); tick();
    bus.vram_ack_i = 1'b1;
    set_write(4'hF, 16'h0010, 16'hABCD);
    tick(); clear_inputs();
    checks++; if (bus.vram_sel_o !== 1'b0) begin errors++; $display("FAIL single_sel_early: got %b want 0", bus.vram_sel_o); end
    checks++; if (bus.level_o !== LVL_W'(1)) begin errors++; $display("FAIL single_level1: got %0d want 1", bus.level_o); end
    tick();
    checks++; if ({bus.vram_sel_o, bus.vram_wr_o, bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o} !== {2'b11, 4'hF, 16'h0010, 16'hABCD}) begin
      errors++; $display("FAIL single_bus: got sel=%b wr=%b m=%h a=%h d=%h want 1 1 f 0010 abcd",
        bus.vram_sel_o, bus.vram_wr_o, bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o); end
    checks++; if (bus.level_o !== LVL_W'(1)) begin errors++; $display("FAIL single_level_bus: got %0d want 1", bus.level_o); end
    tick();
    checks++; if (bus.vram_sel_o !== 1'b0 || bus.level_o !== '0) begin
      errors++; $display("FAIL single_drain: got sel=%b level=%0d want 0 0", bus.vram_sel_o, bus.level_o); end
  endtask

  task automatic test_fill_overflow();
    logic [MASK_W-1:0] em [DEPTH];
    logic [ADDR_W-1:0] ea [DEPTH];
    logic [DATA_W-1:0] ed [DEPTH];
    do_reset(); tick();
    bus.vram_ack_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      em[i] = MASK_W'($urandom); ea[i] = ADDR_W'($urandom); ed[i] = DATA_W'($urandom);
      set_write(em[i], ea[i], ed[i]);
      tick();
    end
    clear_inputs();
    checks++; if (bus.level_o !== LVL_W'(DEPTH) || bus.in_ready_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
      errors++; $display("FAIL fill_full: got level=%0d ready=%b ovf=%b want %0d 0 0", bus.level_o, bus.in_ready_o, bus.overflow_o, DEPTH); end
    set_write(4'h3, 16'hDEAD, 16'hBEEF);
    tick(); clear_inputs();
    checks++; if (bus.overflow_o !== 1'b1 || bus.level_o !== LVL_W'(DEPTH)) begin
      errors++; $display("FAIL fill_drop: got ovf=%b level=%0d want 1 %0d", bus.overflow_o, bus.level_o, DEPTH); end
    bus.vram_ack_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if ({bus.vram_sel_o, bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o} !== {1'b1, em[i], ea[i], ed[i]}) begin
        errors++; $display("FAIL fill_order[%0d]: got sel=%b m=%h a=%h d=%h want 1 %h %h %h",
          i, bus.vram_sel_o, bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o, em[i], ea[i], ed[i]); end
      tick();
    end
    checks++; if (bus.vram_sel_o !== 1'b0 || bus.level_o !== '0 || bus.overflow_o !== 1'b1) begin
      errors++; $display("FAIL fill_end: got sel=%b level=%0d ovf=%b want 0 0 1", bus.vram_sel_o, bus.level_o, bus.overflow_o); end
  endtask

  task automatic test_stall_hold();
    logic [ADDR_W-1:0] sent[$];
    logic [ADDR_W-1:0] seen[$];
    logic [MASK_W+ADDR_W+DATA_W-1:0] snap;
    logic [ADDR_W-1:0] a;
    do_reset(); tick();
    for (int c = 0; c < 30; c++) begin
      if (c < 6) begin a = ADDR_W'($urandom); set_write(MASK_W'($urandom), a, DATA_W'($urandom)); sent.push_back(a); end
      else clear_inputs();
      bus.vram_ack_i = !(c >= 3 && c < 8);
      if (c == 3) snap = {bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o};
      if (c > 3 && c < 8) begin
        checks++; if ({bus.vram_sel_o, bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o} !== {1'b1, snap}) begin
          errors++; $display("FAIL stall_hold[%0d]: got sel=%b bus=%h want 1 %h", c, bus.vram_sel_o,
            {bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o}, snap); end
      end
      if (bus.vram_sel_o && bus.vram_ack_i) seen.push_back(bus.vram_addr_o);
      tick();
    end
    checks++; if (seen.size() != sent.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", seen.size(), sent.size()); end
    for (int i = 0; i < sent.size() && i < seen.size(); i++) begin
      checks++; if (seen[i] !== sent[i]) begin errors++; $display("FAIL stall_order[%0d]: got %h want %h", i, seen[i], sent[i]); end
    end
  endtask

  task automatic test_swap_after_writes();
    int  acks = 0, swaps = 0, acks_at_swap = -1;
    bit  ready_early = 1'b0;
    do_reset(); tick();
    bus.vram_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin set_write(4'hF, ADDR_W'(16'h0100 + i), DATA_W'($urandom)); tick(); end
    clear_inputs();
    bus.swap_req_i = 1'b1; tick(); bus.swap_req_i = 1'b0;
    checks++; if (bus.in_ready_o !== 1'b0 || bus.level_o !== LVL_W'(3) || bus.swap_o !== 1'b0) begin
      errors++; $display("FAIL swapw_pending: got ready=%b level=%0d swap=%b want 0 3 0", bus.in_ready_o, bus.level_o, bus.swap_o); end
    for (int c = 0; c < 30; c++) begin
      if (bus.swap_o) begin swaps++; acks_at_swap = acks; end
      if (swaps == 0 && bus.in_ready_o) ready_early = 1'b1;
      bus.vram_ack_i = (c >= 4);
      if (bus.vram_sel_o && bus.vram_ack_i) acks++;
      tick();
    end
    checks++; if (swaps != 1 || acks_at_swap != 3) begin
      errors++; $display("FAIL swapw_pulse: got swaps=%0d acks_before=%0d want 1 3", swaps, acks_at_swap); end
    checks++; if (ready_early) begin errors++; $display("FAIL swapw_ready: got ready=1 before swap want 0"); end
    checks++; if (bus.in_ready_o !== 1'b1 || bus.level_o !== '0) begin
      errors++; $display("FAIL swapw_idle: got ready=%b level=%0d want 1 0", bus.in_ready_o, bus.level_o); end
  endtask

  task automatic test_write_swap_same();
    int wr_c = -1, sw_c = -1, swaps = 0;
    do_reset(); tick();
    bus.vram_ack_i = 1'b1;
    set_write(4'h5, 16'h1234, 16'h5678); bus.swap_req_i = 1'b1;
    tick(); clear_inputs();
    for (int c = 0; c < 10; c++) begin
      if (bus.vram_sel_o && bus.vram_ack_i) begin
        wr_c = c;
        checks++; if (bus.vram_addr_o !== 16'h1234 || bus.vram_data_out_o !== 16'h5678) begin
          errors++; $display("FAIL same_data: got a=%h d=%h want 1234 5678", bus.vram_addr_o, bus.vram_data_out_o); end
      end
      if (bus.swap_o) begin swaps++; sw_c = c; end
      tick();
    end
    checks++; if (wr_c != 1 || sw_c != 3 || swaps != 1) begin
      errors++; $display("FAIL same_order: got write@%0d swap@%0d swaps=%0d want 1 3 1", wr_c, sw_c, swaps); end
    bus.swap_req_i = 1'b1; tick(); bus.swap_req_i = 1'b0;
    checks++; if (bus.swap_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL empty_swap_n: got swap=%b ready=%b want 0 0", bus.swap_o, bus.in_ready_o); end
    tick();
    checks++; if (bus.swap_o !== 1'b1) begin errors++; $display("FAIL empty_swap_n1: got %b want 1", bus.swap_o); end
    tick();
    checks++; if (bus.swap_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL empty_swap_n2: got swap=%b ready=%b want 0 1", bus.swap_o, bus.in_ready_o); end
  endtask

  task automatic test_reset_mid();
    do_reset(); tick();
    bus.vram_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin set_write(4'hA, ADDR_W'($urandom), DATA_W'($urandom)); tick(); end
    clear_inputs();
    bus.swap_req_i = 1'b1; tick(); bus.swap_req_i = 1'b0;
    set_write(4'h1, 16'h0001, 16'h0002); tick(); clear_inputs();
    checks++; if (bus.vram_sel_o !== 1'b1 || bus.level_o !== LVL_W'(4) || bus.overflow_o !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got sel=%b level=%0d ovf=%b want 1 4 1", bus.vram_sel_o, bus.level_o, bus.overflow_o); end
    #2; reset_i = 1'b0; model_clear(); #1;
    checks++; if ({bus.vram_sel_o, bus.vram_wr_o, bus.swap_o, bus.overflow_o, bus.in_ready_o} !== 5'b0 ||
                  bus.level_o !== '0 || {bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o} !== '0) begin
      errors++; $display("FAIL mid_async: got sel=%b wr=%b swap=%b ovf=%b rdy=%b level=%0d bus=%h want all 0",
        bus.vram_sel_o, bus.vram_wr_o, bus.swap_o, bus.overflow_o, bus.in_ready_o, bus.level_o,
        {bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o}); end
    @(posedge clk); #1; reset_i = 1'b1;
    tick();
    checks++; if (bus.level_o !== '0 || bus.overflow_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.vram_sel_o !== 1'b0) begin
      errors++; $display("FAIL mid_after: got level=%0d ovf=%b ready=%b sel=%b want 0 0 1 0",
        bus.level_o, bus.overflow_o, bus.in_ready_o, bus.vram_sel_o); end
  endtask

  task automatic test_random();
    do_reset(); tick();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        bus.in_sel_i = ($urandom_range(0, 3) != 0);
        bus.in_wr_i = ($urandom_range(0, 7) != 0);
        bus.in_mask_i = MASK_W'($urandom); bus.in_addr_i = ADDR_W'($urandom); bus.in_data_i = DATA_W'($urandom);
        bus.vram_ack_i = ($urandom_range(0, 3) != 0);
        bus.swap_req_i = ($urandom_range(0, 15) == 0);
      end else begin
        clear_inputs(); bus.vram_ack_i = 1'b1;
      end
      tick();
      checks++; if (bus.vram_sel_o !== m_sel || bus.vram_wr_o !== m_sel) begin
        errors++; $display("FAIL rand_sel[%0d]: got sel=%b wr=%b want %b", c, bus.vram_sel_o, bus.vram_wr_o, m_sel); end
      checks++; if (bus.level_o !== LVL_W'(q.size()) || bus.in_ready_o !== exp_ready()) begin
        errors++; $display("FAIL rand_level[%0d]: got level=%0d ready=%b want %0d %b", c, bus.level_o, bus.in_ready_o, q.size(), exp_ready()); end
      checks++; if (bus.swap_o !== m_fire || bus.overflow_o !== m_ovf) begin
        errors++; $display("FAIL rand_flags[%0d]: got swap=%b ovf=%b want %b %b", c, bus.swap_o, bus.overflow_o, m_fire, m_ovf); end
      if (m_sel) begin
        checks++; if ({bus.vram_mask_o, bus.vram_addr_o, bus.vram_data_out_o} !== {q[0].mask, q[0].addr, q[0].data}) begin
          errors++; $display("FAIL rand_data[%0d]: got %h %h %h want %h %h %h", c, bus.vram_mask_o, bus.vram_addr_o,
            bus.vram_data_out_o, q[0].mask, q[0].addr, q[0].data); end
      end
    end
    checks++; if (bus.level_o !== '0) begin errors++; $display("FAIL rand_drain: got level=%0d want 0", bus.level_o); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_stall_hold();
    test_swap_after_writes();
    test_write_swap_same();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
